// File: rtl/alu_result_collector.sv
// Collects one ALU result per select code into an 8-entry table.
// Tracks the running sum, the distinct count and a saturating duplicate count.
//   state   | meaning
//   IDLE    | nothing seen yet
//   COLLECT | some, but not all, select codes seen
//   DONE    | all codes seen; table frozen until ack or clear
module alu_result_collector #(
    parameter int DATA_W = 6,
    parameter int SEL_W  = 3,
    parameter int SUM_W  = 9,
    parameter int DUP_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              clear,
    input  logic              ack,
    input  logic [SEL_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_hit,
    output logic [SUM_W-1:0]  sum,
    output logic [3:0]        count,
    output logic [DUP_W-1:0]  dup_cnt,
    output logic              done
);
    localparam int DEPTH = 2 ** SEL_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      table_q [DEPTH];
    logic [DATA_W-1:0]      table_d [DEPTH];
    logic [DEPTH-1:0]       seen_q, seen_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [3:0]             count_q, count_d;
    logic [DUP_W-1:0]       dup_q, dup_d;
    logic                   accept;

    assign in_ready = (state_q != S_DONE) && !clear;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        table_d = table_q;
        seen_d  = seen_q;
        sum_d   = sum_q;
        count_d = count_q;
        dup_d   = dup_q;
        if (clear || (state_q == S_DONE && ack)) begin
            state_d = S_IDLE;
            for (int i = 0; i < DEPTH; i++) table_d[i] = '0;
            seen_d  = '0;
            sum_d   = '0;
            count_d = '0;
            dup_d   = '0;
        end else if (accept) begin
            table_d[in_sel] = in_data;
            if (seen_q[in_sel]) begin
                // last write wins: swap the old contribution for the new one
                sum_d   = sum_q - SUM_W'(table_q[in_sel]) + SUM_W'(in_data);
                if (dup_q != {DUP_W{1'b1}}) dup_d = dup_q + 1'b1;
                state_d = S_COLLECT;
            end else begin
                seen_d[in_sel] = 1'b1;
                sum_d   = sum_q + SUM_W'(in_data);
                count_d = count_q + 4'd1;
                state_d = (count_q == 4'(DEPTH - 1)) ? S_DONE : S_COLLECT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
            seen_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            dup_q   <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < DEPTH; i++) table_q[i] <= table_d[i];
            seen_q  <= seen_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            dup_q   <= dup_d;
        end
    end

    assign rd_data = table_q[rd_addr];
    assign rd_hit  = seen_q[rd_addr];
    assign sum     = sum_q;
    assign count   = count_q;
    assign dup_cnt = dup_q;
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed plus random bench for alu_result_collector against an array-based reference model.
`timescale 1ns/1ps
module tb_alu_result_collector;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, clear, ack, rd_hit, done;
    logic [5:0] in_data, rd_data;
    logic [2:0] in_sel, rd_addr;
    logic [8:0] sum;
    logic [3:0] count, dup_cnt;

    int total = 0;
    int bad   = 0;
    int raddr = 0;

    int mtab  [8];
    bit mseen [8];
    int mdup;
    bit mdone;

    alu_result_collector dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .clear(clear), .ack(ack),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit), .sum(sum),
        .count(count), .dup_cnt(dup_cnt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 8; i++) begin mtab[i] = 0; mseen[i] = 0; end
        mdup  = 0;
        mdone = 0;
    endtask

    function automatic int msum();
        int s = 0;
        for (int i = 0; i < 8; i++) if (mseen[i]) s += mtab[i];
        return s;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < 8; i++) if (mseen[i]) c++;
        return c;
    endfunction

    task automatic check_all(input string tag, input logic clr);
        chk({tag, ".sum"},      32'(sum),      32'(msum()));
        chk({tag, ".count"},    32'(count),    32'(mcount()));
        chk({tag, ".dup"},      32'(dup_cnt),  32'(mdup));
        chk({tag, ".done"},     32'(done),     32'(mdone));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(!mdone && !clr));
        chk({tag, ".rd_data"},  32'(rd_data),  32'(mseen[raddr] ? mtab[raddr] : 0));
        chk({tag, ".rd_hit"},   32'(rd_hit),   32'(mseen[raddr]));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic step(input string tag, input logic v, input int s, input int d,
                        input logic c, input logic a);
        bit acc;
        in_valid = v; in_sel = 3'(s); in_data = 6'(d); clear = c; ack = a;
        rd_addr  = 3'(raddr);
        acc = v && !mdone && !c;
        @(posedge clk);
        if (c || (mdone && a)) begin
            mreset();
        end else if (acc) begin
            if (mseen[s]) mdup = (mdup < 15) ? mdup + 1 : 15;
            mtab[s]  = d;
            mseen[s] = 1;
            mdone    = (mcount() == 8);
        end
        #1;
        check_all(tag, c);
        raddr = (raddr + 1) % 8;
    endtask

    initial begin
        int sweep [8] = '{25, 1, 12, 13, 14, 27, 63, 0};
        mreset();
        rst_n = 1'b0; in_valid = 0; in_sel = 0; in_data = 0; clear = 0; ack = 0; rd_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0);
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready_after", 32'(in_ready), 32'd1);

        // asynchronous reset in the middle of a collection
        raddr = 2;
        step("pre_rst", 1, 2, 9, 0, 0);
        chk("pre_rst.data9", 32'(sum), 32'd9);
        in_valid = 0;
        #3 rst_n = 1'b0;
        #1;
        mreset();
        rd_addr = 3'd2;
        chk("async_rst.sum",    32'(sum),    32'd0);
        chk("async_rst.count",  32'(count),  32'd0);
        chk("async_rst.rd_hit", 32'(rd_hit), 32'd0);
        chk("async_rst.rd_data",32'(rd_data),32'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("async_rst.in_ready", 32'(in_ready), 32'd1);

        // full sweep
        for (int i = 0; i < 8; i++) begin
            step("sweep", 1, i, sweep[i], 0, 0);
            chk("sweep.count_seq", 32'(count), 32'(i + 1));
        end
        chk("sweep.done",     32'(done),     32'd1);
        chk("sweep.sum155",   32'(sum),      32'd155);
        chk("sweep.in_ready", 32'(in_ready), 32'd0);
        rd_addr = 3'd6;
        #1;
        chk("sweep.rd6", 32'(rd_data), 32'd63);
        chk("sweep.hit6", 32'(rd_hit), 32'd1);

        // backpressure in DONE, then ack releases the held item
        for (int i = 0; i < 5; i++) step("bp_hold", 1, 1, 50, 0, 0);
        chk("bp_hold.sum", 32'(sum), 32'd155);
        step("bp_ack", 1, 1, 50, 0, 1);
        chk("bp_ack.done",  32'(done),  32'd0);
        chk("bp_ack.count", 32'(count), 32'd0);
        step("bp_accept", 1, 1, 50, 0, 0);
        chk("bp_accept.count", 32'(count), 32'd1);

        // ack outside DONE is ignored
        step("ack_ign_a", 1, 4, 7, 0, 0);
        step("ack_ign_b", 1, 5, 11, 0, 0);
        step("ack_ign", 0, 0, 0, 0, 1);
        chk("ack_ign.count", 32'(count), 32'd3);
        chk("ack_ign.sum",   32'(sum),   32'd68);

        // clear beats a simultaneous valid and ack
        step("clr_a", 1, 6, 3, 0, 0);
        step("clr_b", 1, 7, 2, 0, 0);
        chk("clr.count5", 32'(count), 32'd5);
        step("clr", 1, 0, 40, 1, 1);
        chk("clr.count", 32'(count), 32'd0);
        chk("clr.sum",   32'(sum),   32'd0);

        // duplicates and dup_cnt saturation
        raddr = 3;
        step("dup_a", 1, 3, 10, 0, 0);
        raddr = 3;
        step("dup_b", 1, 3, 4, 0, 0);
        chk("dup.count", 32'(count),   32'd1);
        chk("dup.cnt1",  32'(dup_cnt), 32'd1);
        chk("dup.sum4",  32'(sum),     32'd4);
        chk("dup.rd3",   32'(rd_data), 32'd4);
        for (int i = 0; i < 16; i++) step("dup_sat", 1, 3, int'($urandom_range(63)), 0, 0);
        chk("dup.sat15", 32'(dup_cnt), 32'd15);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            step("rand", 1'($urandom_range(3) != 0), int'($urandom_range(7)),
                 int'($urandom_range(63)), 1'($urandom_range(24) == 0),
                 1'($urandom_range(3) == 0));
        end

        in_valid = 0; clear = 0; ack = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream stage of the 8-function ALU (F_8_ALU). Takes the 6-bit ALU result and the 3-bit select code that produced it over a valid/ready handshake.
- Stores one result per select code in an 8-entry table and keeps a running sum, a distinct count and a duplicate count.
- Raises done once all 8 functions have reported. Results are read back through a registered-table read port by the checker or controller.

Parameters:
- DATA_W, 6, width of ALU result (matches ALU out).
- SEL_W, 3, width of select code; table depth = 2**SEL_W = 8.
- SUM_W, 9, running-sum width; 8*63 = 504 < 512, so the sum can never overflow.
- DUP_W, 4, duplicate-counter width; saturates.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  result present on in_data/in_sel.
- in_ready  out  1  collector can accept.
- in_data  in  DATA_W  ALU result (ALU out).
- in_sel  in  SEL_W  select code that produced in_data.
- clear  in  1  synchronous flush of all state.
- ack  in  1  consumer acknowledges done.
- rd_addr  in  SEL_W  table read index.
- rd_data  out  DATA_W  table[rd_addr], combinational from registers.
- rd_hit  out  1  seen[rd_addr].
- sum  out  SUM_W  sum of current table entries.
- count  out  4  number of distinct select codes seen, 0..8.
- dup_cnt  out  DUP_W  accepted writes to an already-seen code.
- done  out  1  all 8 codes seen.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low, with ports named clk and rst_n.
- Reset state: state=IDLE; table, seen, sum, count and dup_cnt all 0; done=0; in_ready=1 once rst_n deasserts. Reset asserted mid-collection discards everything immediately.
- FSM states:
  - IDLE: seen==0.
  - COLLECT: 0 < count < 8.
  - DONE: seen==8'hFF.
- FSM transitions:
  - IDLE->COLLECT on the first accept.
  - COLLECT->DONE on the accept that sets the last seen bit.
  - DONE->IDLE on ack.
  - Any state->IDLE on clear.
- Handshake:
  - in_ready = (state != DONE) && !clear.
  - accept = in_valid && in_ready.
  - in_valid held without ready must not lose or duplicate data; the bench holds it.
- Accept of a new code (seen[sel]=0): table[sel]<=data; seen[sel]<=1; sum<=sum+data; count<=count+1.
- Accept of a duplicate code (seen[sel]=1): table[sel]<=data (last write wins); sum<=sum-table[sel]+data; dup_cnt<=min(dup_cnt+1, 2**DUP_W-1). count is unchanged.
- Latency:
  - An accepted entry is visible on rd_data/rd_hit/sum/count the cycle after the accept.
  - done asserts the cycle after the completing accept.
- done = (state==DONE). In DONE, in_ready=0 and the table is frozen, readable indefinitely.
- ack is honoured only in DONE; ack in IDLE/COLLECT is ignored. ack in DONE clears table, seen, sum, count and dup_cnt next cycle.
- clear has priority over accept and ack. An in_valid on the clear cycle is not accepted, because in_ready is low.
- Unseen entries read rd_data=0 and rd_hit=0.
- No X on any output after reset. sum always equals the sum of the table entries whose seen bit is set.

Test Plan:
- Reset mid-collection: accept sel=2/data=9, pulse rst_n low asynchronously between edges -> all outputs 0 immediately; state IDLE; in_ready=1 after release.
- Full sweep: accept sel 0..7 with data 25,1,12,13,14,27,63,0 back-to-back -> count 1..8 each cycle; done=1 the cycle after the sel=7 accept; sum=155; in_ready=0; rd_addr=6 -> rd_data=63, rd_hit=1.
- Duplicate: sel=3/data=10 then sel=3/data=4 -> count=1, dup_cnt=1, sum=4, rd_data[3]=4. Then 16 more sel=3 writes -> dup_cnt saturates at 15.
- Backpressure: reach DONE, hold in_valid=1 with sel=1/data=50 for 5 cycles -> no accept, table unchanged. ack=1 -> next cycle done=0, sum=0, count=0, in_ready=1; the held sel=1/data=50 is then accepted, giving count=1.
- clear priority: in COLLECT with count=5, assert clear, in_valid and ack together -> no accept; next cycle IDLE, all zero.
- ack ignored: count=3, pulse ack -> count stays 3, sum unchanged, done=0.
